// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and writeback formatter: MemToReg select, sub-word
// load extraction with sign/zero extension, $0 write suppression, retire counter.
module mem_wb_writeback (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        In_Stall,
  input  logic        In_Flush,
  input  logic        In_Valid,
  input  logic [1:0]  In_WBControl,
  input  logic [31:0] In_ALUResult,
  input  logic [31:0] In_MemData,
  input  logic [1:0]  In_ByteAddr,
  input  logic [2:0]  In_LoadType,
  input  logic [4:0]  In_Rd,
  output logic [4:0]  Out_Rd,
  output logic [31:0] Out_WriteData,
  output logic        Out_RegWrite,
  output logic        Out_Valid,
  output logic [31:0] Out_RetireCount
);

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_BU = 3'b010,
    LD_H  = 3'b011,
    LD_HU = 3'b100
  } load_type_e;

  typedef struct packed {
    logic        valid;
    logic        mem_to_reg;
    logic        reg_write;
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [1:0]  byte_addr;
    logic [2:0]  load_type;
    logic [4:0]  rd;
  } stage_t;

  stage_t      stage_d, stage_q;
  logic [31:0] retire_cnt_d, retire_cnt_q;

  // Flush outranks stall, so a bubble always lands even while the stage is held.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    stage_d      = stage_q;
    retire_cnt_d = retire_cnt_q;
    if (In_Flush) begin
      stage_d = '0;
    end else if (!In_Stall) begin
      stage_d.valid      = In_Valid;
      stage_d.mem_to_reg = In_WBControl[1];
      stage_d.reg_write  = In_WBControl[0];
      stage_d.alu_result = In_ALUResult;
      stage_d.mem_data   = In_MemData;
      stage_d.byte_addr  = In_ByteAddr;
      stage_d.load_type  = In_LoadType;
      stage_d.rd         = In_Rd;
      if (In_Valid) begin
        retire_cnt_d = retire_cnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    if (Reset) begin
      stage_q      <= '0;
      retire_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_data;

  always_comb begin
    byte_sel  = 8'h00;
    half_sel  = stage_q.byte_addr[1] ? stage_q.mem_data[31:16] : stage_q.mem_data[15:0];
    load_data = stage_q.mem_data;
    case (stage_q.byte_addr)
      2'd0:    byte_sel = stage_q.mem_data[7:0];
      2'd1:    byte_sel = stage_q.mem_data[15:8];
      2'd2:    byte_sel = stage_q.mem_data[23:16];
      default: byte_sel = stage_q.mem_data[31:24];
    endcase
    // Encodings 101-111 fall through to the full-word default.
    case (stage_q.load_type)
      LD_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      LD_BU:   load_data = {24'h000000, byte_sel};
      LD_H:    load_data = {{16{half_sel[15]}}, half_sel};
      LD_HU:   load_data = {16'h0000, half_sel};
      default: load_data = stage_q.mem_data;
    endcase
  end

  assign Out_Rd          = stage_q.rd;
  assign Out_Valid       = stage_q.valid;
  assign Out_RegWrite    = stage_q.valid & stage_q.reg_write & (stage_q.rd != 5'd0);
  assign Out_WriteData   = stage_q.mem_to_reg ? load_data : stage_q.alu_result;
  assign Out_RetireCount = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Directed, table-driven bench for mem_wb_writeback with hand-written sequences
// for reset, mid-stream reset and counter wrap.
module tb_mem_wb_writeback;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        In_Stall, In_Flush, In_Valid;
  logic [1:0]  In_WBControl;
  logic [31:0] In_ALUResult, In_MemData;
  logic [1:0]  In_ByteAddr;
  logic [2:0]  In_LoadType;
  logic [4:0]  In_Rd;
  logic [4:0]  Out_Rd;
  logic [31:0] Out_WriteData;
  logic        Out_RegWrite, Out_Valid;
  logic [31:0] Out_RetireCount;

  always #5 Clk = ~Clk;

  mem_wb_writeback dut (
    .Clk(Clk), .Reset(Reset),
    .In_Stall(In_Stall), .In_Flush(In_Flush), .In_Valid(In_Valid),
    .In_WBControl(In_WBControl), .In_ALUResult(In_ALUResult),
    .In_MemData(In_MemData), .In_ByteAddr(In_ByteAddr),
    .In_LoadType(In_LoadType), .In_Rd(In_Rd),
    .Out_Rd(Out_Rd), .Out_WriteData(Out_WriteData),
    .Out_RegWrite(Out_RegWrite), .Out_Valid(Out_Valid),
    .Out_RetireCount(Out_RetireCount)
  );

  typedef struct {
    logic        stall, flush, valid;
    logic [1:0]  wbc;
    logic [31:0] alu, mem;
    logic [1:0]  ba;
    logic [2:0]  lt;
    logic [4:0]  rd;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_rw, e_v;
    logic [31:0] e_cnt;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic s, f, v, input logic [1:0] wbc, input logic [31:0] alu, mem,
    input logic [1:0] ba, input logic [2:0] lt, input logic [4:0] rd,
    input logic [4:0] e_rd, input logic [31:0] e_wd, input logic e_rw, e_v,
    input logic [31:0] e_cnt);
    vec_t t;
    t.stall = s; t.flush = f; t.valid = v; t.wbc = wbc; t.alu = alu; t.mem = mem;
    t.ba = ba; t.lt = lt; t.rd = rd; t.e_rd = e_rd; t.e_wd = e_wd;
    t.e_rw = e_rw; t.e_v = e_v; t.e_cnt = e_cnt;
    return t;
  endfunction

  task automatic drive(input vec_t t);
    In_Stall = t.stall; In_Flush = t.flush; In_Valid = t.valid;
    In_WBControl = t.wbc; In_ALUResult = t.alu; In_MemData = t.mem;
    In_ByteAddr = t.ba; In_LoadType = t.lt; In_Rd = t.rd;
  endtask

  task automatic check_all(input string tag, input logic [4:0] rd, input logic [31:0] wd,
                           input logic rw, input logic v, input logic [31:0] cnt);
    check({tag, ".rd"},  {27'd0, Out_Rd}, {27'd0, rd});
    check({tag, ".wd"},  Out_WriteData, wd);
    check({tag, ".rw"},  {31'd0, Out_RegWrite}, {31'd0, rw});
    check({tag, ".v"},   {31'd0, Out_Valid}, {31'd0, v});
    check({tag, ".cnt"}, Out_RetireCount, cnt);
  endtask

  localparam logic [31:0] MD = 32'h80F17F85;

  initial begin
    // stall flush valid wbc alu mem ba lt rd | e_rd e_wd e_rw e_v e_cnt
    vecs.push_back(mk(0,0,1,2'b01,32'd15,MD,2'd0,3'd0,5'd9,   5'd9, 32'd15,1,1,32'd1));
    vecs.push_back(mk(0,0,1,2'b11,32'd0,MD,2'd0,3'd1,5'd3,    5'd3, 32'hFFFFFF85,1,1,32'd2));
    vecs.push_back(mk(0,0,1,2'b11,32'd0,MD,2'd0,3'd2,5'd3,    5'd3, 32'h00000085,1,1,32'd3));
    vecs.push_back(mk(0,0,1,2'b11,32'd0,MD,2'd1,3'd1,5'd3,    5'd3, 32'h0000007F,1,1,32'd4));
    vecs.push_back(mk(0,0,1,2'b11,32'd0,MD,2'd2,3'd3,5'd3,    5'd3, 32'hFFFF80F1,1,1,32'd5));
    vecs.push_back(mk(0,0,1,2'b11,32'd0,MD,2'd2,3'd4,5'd3,    5'd3, 32'h000080F1,1,1,32'd6));
    vecs.push_back(mk(0,0,1,2'b11,32'd0,MD,2'd3,3'd0,5'd3,    5'd3, MD,1,1,32'd7));
    vecs.push_back(mk(0,0,1,2'b11,32'd0,MD,2'd1,3'd7,5'd3,    5'd3, MD,1,1,32'd8));
    vecs.push_back(mk(0,0,1,2'b11,32'd0,MD,2'd3,3'd1,5'd3,    5'd3, 32'hFFFFFF80,1,1,32'd9));
    vecs.push_back(mk(0,0,1,2'b11,32'd0,MD,2'd1,3'd3,5'd3,    5'd3, 32'h00007F85,1,1,32'd10));
    vecs.push_back(mk(0,0,1,2'b01,32'hDEADBEEF,MD,2'd0,3'd0,5'd0, 5'd0, 32'hDEADBEEF,0,1,32'd11));
    vecs.push_back(mk(0,0,0,2'b01,32'd1,MD,2'd0,3'd0,5'd4,    5'd4, 32'd1,0,0,32'd11));
    vecs.push_back(mk(0,0,1,2'b10,32'd0,MD,2'd3,3'd2,5'd6,    5'd6, 32'h00000080,0,1,32'd12));
    vecs.push_back(mk(0,0,1,2'b01,32'd7,MD,2'd0,3'd0,5'd5,    5'd5, 32'd7,1,1,32'd13));
    vecs.push_back(mk(1,0,1,2'b11,32'd99,MD,2'd0,3'd1,5'd12,  5'd5, 32'd7,1,1,32'd13));
    vecs.push_back(mk(1,0,1,2'b01,32'd100,32'd0,2'd2,3'd3,5'd13, 5'd5, 32'd7,1,1,32'd13));
    vecs.push_back(mk(1,0,0,2'b00,32'd101,32'd1,2'd1,3'd0,5'd0,  5'd5, 32'd7,1,1,32'd13));
    vecs.push_back(mk(1,1,1,2'b01,32'd55,MD,2'd0,3'd0,5'd8,   5'd0, 32'd0,0,0,32'd13));
    vecs.push_back(mk(0,1,1,2'b11,32'd55,MD,2'd0,3'd0,5'd8,   5'd0, 32'd0,0,0,32'd13));
    vecs.push_back(mk(0,0,1,2'b01,32'h55,MD,2'd0,3'd0,5'd2,   5'd2, 32'h55,1,1,32'd14));

    // Reset held for two cycles with a live-looking entry on the inputs.
    Reset = 1'b1;
    drive(mk(0,0,1,2'b11,32'h1234,MD,2'd1,3'd1,5'd9, 5'd0,32'd0,0,0,32'd0));
    repeat (2) @(posedge Clk);
    #1 check_all("reset", 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);

    @(negedge Clk);
    Reset = 1'b0;
    drive(mk(0,0,0,2'b01,32'd3,MD,2'd0,3'd0,5'd1, 5'd0,32'd0,0,0,32'd0));
    @(posedge Clk);
    #1 check("bubble.cnt", Out_RetireCount, 32'd0);
    check("bubble.v", {31'd0, Out_Valid}, 32'd0);
    check("bubble.rw", {31'd0, Out_RegWrite}, 32'd0);

    foreach (vecs[i]) begin
      @(negedge Clk);
      drive(vecs[i]);
      @(posedge Clk);
      #1 check_all($sformatf("vec%0d", i), vecs[i].e_rd, vecs[i].e_wd,
                   vecs[i].e_rw, vecs[i].e_v, vecs[i].e_cnt);
    end

    // Reset mid-stream discards the pending entry on its first sampled edge.
    @(negedge Clk);
    drive(mk(0,0,1,2'b01,32'h77,MD,2'd0,3'd0,5'd7, 5'd0,32'd0,0,0,32'd0));
    @(posedge Clk);
    #1 check("pre_rst.rw", {31'd0, Out_RegWrite}, 32'd1);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1 check_all("mid_rst", 5'd0, 32'd0, 1'b0, 1'b0, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;

    // Counter wrap: preload the counter, then capture one valid entry.
    In_Stall = 1'b1;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.retire_cnt_q;
    drive(mk(0,0,1,2'b01,32'hA5,MD,2'd0,3'd0,5'd11, 5'd0,32'd0,0,0,32'd0));
    @(posedge Clk);
    #1 check_all("wrap", 5'd11, 32'hA5, 1'b1, 1'b1, 32'd0);
    @(negedge Clk);
    @(posedge Clk);
    #1 check("post_wrap.cnt", Out_RetireCount, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
# mem_wb_writeback

MEM/WB pipeline register and writeback formatter for the five-stage MIPS datapath. It captures the MEM-stage result and control each cycle and drives the register-file write port of the ID stage (`In_Rd`, `In_WriteData`, `In_RegWrite` on the ID side). It performs the MemToReg select and sub-word load extraction and sign/zero extension, suppresses writes to $0, and keeps a retired-instruction counter.

## Interface
- Parameters: none; datapath fixed at 32 bits, register address at 5 bits.
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- In_Stall  input  1  hold the stage register; no capture.
- In_Flush  input  1  load a bubble instead of the incoming entry.
- In_Valid  input  1  the incoming MEM entry is a real instruction.
- In_WBControl  input  2  [1] MemToReg, [0] RegWrite.
- In_ALUResult  input  32  ALU result from MEM.
- In_MemData  input  32  data-memory read word.
- In_ByteAddr  input  2  low address bits of the load.
- In_LoadType  input  3  000 lw, 001 lb, 010 lbu, 011 lh, 100 lhu; 101–111 treated as lw.
- In_Rd  input  5  destination register.
- Out_Rd  output  5  write address to the ID register file.
- Out_WriteData  output  32  write data to the ID register file.
- Out_RegWrite  output  1  write enable to the ID register file.
- Out_Valid  output  1  the stage register holds a real instruction.
- Out_RetireCount  output  32  count of valid instructions captured.

## Operation
- Stage register fields: valid, MemToReg, RegWrite, ALUResult, MemData, ByteAddr, LoadType, Rd.
- Each rising edge, apply the first matching rule in this order:
  - Reset: clear all fields to 0 and clear the counter to 0.
  - In_Flush: load a bubble. All fields go to 0. The counter does not change.
  - In_Stall: hold all fields and hold the counter.
  - Otherwise: capture all inputs. If In_Valid=1, the counter increments by 1 and wraps from 0xFFFFFFFF to 0.
- Out_RegWrite = valid & RegWrite & (Rd != 0). A bubble or an Rd of $0 never writes.
- Out_Rd = registered Rd. Out_Valid = registered valid.
- Write data comes only from registered fields:
  - MemToReg=0: Out_WriteData = ALUResult.
  - MemToReg=1: extract from MemData as below.
- Load extraction uses little-endian lanes:
  - byte lane k occupies bits [8k+7:8k], with k = ByteAddr;
  - the halfword is bits [31:16] if ByteAddr[1]=1, otherwise bits [15:0]; ByteAddr[0] is ignored;
  - lb and lh sign-extend, lbu and lhu zero-extend;
  - lw uses MemData unchanged, and ByteAddr is ignored.
- Reset values of all outputs: Out_Rd=0, Out_WriteData=0, Out_RegWrite=0, Out_Valid=0, Out_RetireCount=0.

## Timing
- Latency: an entry presented with no stall and no flush before edge N drives the outputs after edge N. The ID register file commits it at edge N+1.
- The outputs are combinational from the stage register only. No combinational path runs from any In_* port to any Out_* port.
- Stall lasting several cycles: the outputs stay constant. Out_RegWrite stays asserted, so the register file rewrites the same value each cycle, which is harmless and required.
- Flush and Stall together: flush wins, and a bubble is loaded.
- Reset asserted mid-stream: the pending entry is discarded. Out_RegWrite=0 from the first edge at which Reset is sampled high.
- Counter wrap: a capture of a valid entry at 0xFFFFFFFF gives 0. No other flag is produced.

## Test plan
- **Reset:** hold Reset for 2 cycles with arbitrary inputs. Required: all outputs 0. Release Reset and present a bubble (In_Valid=0). Required: Out_RetireCount stays 0.
- **ALU writeback:** In_Valid=1, WBControl=01, ALUResult=15, Rd=9, no stall. Required one edge later: Out_Rd=9, Out_WriteData=15, Out_RegWrite=1, Out_RetireCount=1.
- **Loads:** MemData=0x80F17F85, WBControl=11. Required Out_WriteData for each case:
  - lb, ByteAddr=0: 0xFFFFFF85;
  - lbu, ByteAddr=0: 0x00000085;
  - lb, ByteAddr=1: 0x0000007F;
  - lh, ByteAddr=2: 0xFFFF80F1;
  - lhu, ByteAddr=2: 0x000080F1;
  - lw: 0x80F17F85.
- **$0 suppression:** Rd=0, WBControl=01, ALUResult=0xDEADBEEF. Required: Out_RegWrite=0, Out_Valid=1, counter increments.
- **Stall, then flush:** capture Rd=5 with ALUResult=7, then assert In_Stall for 3 cycles while the inputs change. Required: outputs stay Rd=5, data 7. Then assert In_Flush and In_Stall together. Required: Out_Valid=0, Out_RegWrite=0, counter unchanged.
- **Counter wrap:** preload the counter to 0xFFFFFFFF by forcing it or by a long run, then capture a valid entry. Required: Out_RetireCount=0.
